// File: rtl/ifetch_pf.sv
// ifetch_pf: prefetching instruction-fetch unit.
// Issues sequential word fetches under a credit limit, buffers in-order responses
// in a DEPTH-entry queue and presents {inst, pc, pc+4} to the decoder.
// A redirect flushes the queue and marks every outstanding response as stale.
module ifetch_pf #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] link_addr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [31:0]       q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  drop;

    logic [ADDR_W-1:0] target;
    logic              credit_ok;
    logic              issue;
    logic              rsp_keep;
    logic              pop;
    logic [CNT_W-1:0]  inflight_nxt;

    // Handshake qualification and credit accounting.
    always_comb begin
        target         = redirect_pc & ~ADDR_W'(3);
        credit_ok      = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
        imem_req_valid = !reset && !redirect_valid && credit_ok;
        issue          = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (drop == '0);
        inst_valid     = (count != '0);
        pop            = inst_valid && inst_ready;
        inflight_nxt   = inflight + CNT_W'(issue) - CNT_W'(imem_rsp_valid);
    end

    // Head of queue is shown fall-through; link address wraps with the PC width.
    always_comb begin
        imem_req_addr = fetch_pc;
        inst_out      = q_inst[rd_ptr];
        inst_pc       = q_pc[rd_ptr];
        link_addr     = q_pc[rd_ptr] + ADDR_W'(4);
    end

    // Fetch PC, response PC, queue storage and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[PTR_W'(i)] <= '0;
                q_pc[PTR_W'(i)]   <= RESET_PC;
            end
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                // Every request still outstanding after this edge belongs to the
                // old path, including ones already marked stale, so the new drop
                // count is simply the post-edge inflight count.
                fetch_pc <= target;
                rsp_pc   <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= inflight_nxt;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (rsp_keep) begin
                    q_inst[wr_ptr] <= imem_rsp_data;
                    q_pc[wr_ptr]   <= rsp_pc;
                    wr_ptr         <= wr_ptr + PTR_W'(1);
                    rsp_pc         <= rsp_pc + ADDR_W'(4);
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(rsp_keep) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_pf.sv
// tb_ifetch_pf: scoreboard bench for ifetch_pf (32-bit default and 8-bit wrap instance).
`timescale 1ns/1ps
module tb_ifetch_pf;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- main DUT (ADDR_W = 32) ----------------
    logic        reset = 1'b1;
    logic        req_valid, req_ready, rsp_valid;
    logic [31:0] req_addr, rsp_data;
    logic        inst_valid, inst_ready, redirect_valid;
    logic [31:0] inst_out, inst_pc, link_addr, redirect_pc;

    ifetch_pf #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .link_addr(link_addr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // ---------------- wrap DUT (ADDR_W = 8) ----------------
    logic        reset8 = 1'b1;
    logic        req8_valid, rsp8_valid, inst8_valid, inst8_ready;
    logic [7:0]  req8_addr, inst8_pc, link8;
    logic [31:0] rsp8_data, inst8_out;

    ifetch_pf #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hF8)) dut8 (
        .clock(clock), .reset(reset8),
        .imem_req_valid(req8_valid), .imem_req_ready(1'b1), .imem_req_addr(req8_addr),
        .imem_rsp_valid(rsp8_valid), .imem_rsp_data(rsp8_data),
        .inst_valid(inst8_valid), .inst_ready(inst8_ready), .inst_out(inst8_out),
        .inst_pc(inst8_pc), .link_addr(link8),
        .redirect_valid(1'b0), .redirect_pc(8'h00)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // ---------------- memory model, main DUT ----------------
    pend_t       pend[$];
    int          mem_lat     = 1;
    int          n_req       = 0;
    int          outstanding = 0;
    logic [31:0] req_log[$];

    initial begin
        req_ready      = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
    end

    // Responses are driven at the falling edge; accepted requests are logged 1ns later.
    always @(negedge clock) begin
        pend_t p;
        if (reset) begin
            pend.delete();
            outstanding = 0;
            rsp_valid   = 1'b0;
            rsp_data    = '0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = pend[0].addr >> 2;
            void'(pend.pop_front());
            outstanding--;
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (req_valid && req_ready) begin
            p.addr = req_addr;
            p.due  = cyc + mem_lat;
            pend.push_back(p);
            req_log.push_back(req_addr);
            n_req++;
            outstanding++;
        end
        if (!reset && outstanding > int'(DEPTH)) begin
            chk("credit_limit", 32'(outstanding), 32'(DEPTH));
        end
    end

    // ---------------- scoreboard, main DUT ----------------
    exp_t exp_q[$];
    int   n_del = 0, first_del = 0, last_del = 0;

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    // Decoder accepts only while the scoreboard still expects something.
    always @(negedge clock) begin
        #1;
        inst_ready = (exp_q.size() > 0);
    end

    // Monitor: compares every instruction handed to the decoder.
    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!reset && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_inst: got pc %h, none expected", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_out", inst_out, e.inst);
                chk("link_addr", link_addr, e.pc + 32'd4);
                if (n_del == 0) first_del = cyc;
                last_del = cyc;
                n_del++;
            end
        end
    end

    // ---------------- memory model + scoreboard, wrap DUT ----------------
    logic        p8_v = 1'b0;
    logic [7:0]  p8_a = '0;
    logic [7:0]  log8[$];
    exp_t        exp8[$];

    always @(negedge clock) begin
        if (reset8) begin
            rsp8_valid = 1'b0;
            rsp8_data  = '0;
            p8_v       = 1'b0;
        end else begin
            rsp8_valid = p8_v;
            rsp8_data  = 32'(p8_a >> 2);
            p8_v       = 1'b0;
        end
        #1;
        inst8_ready = (exp8.size() > 0);
        if (!reset8 && req8_valid) begin
            p8_v = 1'b1;
            p8_a = req8_addr;
            log8.push_back(req8_addr);
        end
    end

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!reset8 && inst8_valid && inst8_ready) begin
            if (exp8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_inst8: got pc %h, none expected", inst8_pc);
            end else begin
                e = exp8.pop_front();
                chk("inst8_pc", 32'(inst8_pc), e.pc);
                chk("inst8_out", inst8_out, e.inst);
                chk("link8", 32'(link8), 32'(8'(e.pc + 32'd4)));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        tick();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        #3;
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_link_addr", link_addr, 32'h4);
        n_req = 0;
        req_log.delete();
        tick();
        reset = 1'b0;
        #3;
        chk("first_req_valid", 32'(req_valid), 32'd1);
        chk("first_req_addr", req_addr, 32'h0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() > 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: %0d instructions still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int k;

        // 1) 1-cycle memory, decoder always ready: one instruction per cycle.
        mem_lat = 1;
        do_reset();
        n_del = 0;
        for (int i = 0; i < 8; i++) expect_inst(32'(4 * i), 32'(i));
        drain("stream");
        chk("stream_count", 32'(n_del), 32'd8);
        chk("stream_rate", 32'(last_del - first_del), 32'd7);

        // 2) Decoder stalled 20 cycles: exactly DEPTH requests, then drain in order.
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        #3;
        chk("stall_req_count", 32'(n_req), 32'(DEPTH));
        chk("stall_req_valid", 32'(req_valid), 32'd0);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_inst_pc", inst_pc, 32'h0);
        expect_inst(32'h0, 32'd0);
        expect_inst(32'h4, 32'd1);
        expect_inst(32'h8, 32'd2);
        expect_inst(32'hC, 32'd3);
        drain("stall");

        // 3) 3-cycle memory, redirect to 0x40 with 3 requests in flight.
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        #3;
        chk("redir_inst_valid", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(req_valid), 32'd1);
        chk("redir_req_addr", req_addr, 32'h40);
        expect_inst(32'h40, 32'h10);
        expect_inst(32'h44, 32'h11);
        expect_inst(32'h48, 32'h12);
        expect_inst(32'h4C, 32'h13);
        drain("redir");

        // 4) Redirect coinciding with a response and a pop.
        mem_lat = 1;
        do_reset();
        expect_inst(32'h0, 32'd0);
        expect_inst(32'h4, 32'd1);
        expect_inst(32'h8, 32'd2);
        k = 0;
        while (exp_q.size() != 1 && k < 50) begin
            tick();
            k++;
        end
        chk("coinc_setup", 32'(exp_q.size()), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #3;
        chk("coinc_pop", 32'(inst_valid && inst_ready), 32'd1);
        chk("coinc_rsp", 32'(rsp_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #3;
        chk("coinc_inst_valid", 32'(inst_valid), 32'd0);
        chk("coinc_req_addr", req_addr, 32'h200);
        expect_inst(32'h200, 32'h80);
        expect_inst(32'h204, 32'h81);
        drain("coinc");

        // 5) Unaligned redirect target is forced to a word boundary.
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        req_log.delete();
        tick();
        redirect_valid = 1'b0;
        expect_inst(32'h100, 32'h40);
        expect_inst(32'h104, 32'h41);
        drain("align");
        chk("align_log_size", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) begin
            chk("align_req0", req_log[0], 32'h100);
            chk("align_req1", req_log[1], 32'h104);
        end

        // 6) Back-to-back redirects with 3-cycle memory: the last one wins.
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_pc    = 32'hC0;
        tick();
        redirect_valid = 1'b0;
        #3;
        chk("b2b_req_addr", req_addr, 32'hC0);
        expect_inst(32'hC0, 32'h30);
        expect_inst(32'hC4, 32'h31);
        expect_inst(32'hC8, 32'h32);
        drain("b2b");

        // 7) 8-bit address space wraps from 0xFC to 0x00.
        tick();
        tick();
        #3;
        chk("w8_rst_pc", 32'(inst8_pc), 32'hF8);
        chk("w8_rst_link", 32'(link8), 32'hFC);
        chk("w8_rst_req_addr", 32'(req8_addr), 32'hF8);
        tick();
        reset8 = 1'b0;
        #3;
        chk("w8_first_req", 32'(req8_valid), 32'd1);
        exp8.push_back('{pc: 32'hF8, inst: 32'h3E});
        exp8.push_back('{pc: 32'hFC, inst: 32'h3F});
        exp8.push_back('{pc: 32'h00, inst: 32'h00});
        exp8.push_back('{pc: 32'h04, inst: 32'h01});
        k = 0;
        while (exp8.size() > 0 && k < 100) begin
            tick();
            k++;
        end
        chk("w8_drained", 32'(exp8.size()), 32'd0);
        chk("w8_log_size", 32'(log8.size() >= 4), 32'd1);
        if (log8.size() >= 4) begin
            chk("w8_req0", 32'(log8[0]), 32'hF8);
            chk("w8_req1", 32'(log8[1]), 32'hFC);
            chk("w8_req2", 32'(log8[2]), 32'h00);
            chk("w8_req3", 32'(log8[3]), 32'h04);
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, bad=%0d", bad);
        $fatal(1);
    end

endmodule
